// File: rtl/sopc_run_ctrl_pkg.sv
// Shared run-controller types: run FSM state encoding and reset polarity.
// No logic; imported by the controller top and its loop detector.
package sopc_run_ctrl_pkg;

    localparam logic RstEnable  = 1'b1;
    localparam logic RstDisable = 1'b0;

    typedef enum logic [1:0] {
        RunHold    = 2'd0,
        RunRun     = 2'd1,
        RunHalted  = 2'd2,
        RunTimeout = 2'd3
    } run_state_e;

endpackage

// File: rtl/sopc_run_ctrl_pc_loop_detector.sv
// Flags a core PC stuck in a period-1 or period-2 self-loop for HALT_REPEAT matches.
// Latency: halt_o is combinational from pc_i and the two-deep PC history.
// Backpressure: none; history only advances while en is high.
module sopc_run_ctrl_pc_loop_detector
    import sopc_run_ctrl_pkg::*;
#(
    parameter int unsigned HALT_REPEAT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] pc_i,
    output logic        halt_o
);

    localparam int unsigned REP_W = (HALT_REPEAT > 1) ? $clog2(HALT_REPEAT) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(HALT_REPEAT - 1);

    logic [31:0]      pc_d1_q, pc_d1_d;
    logic [31:0]      pc_d2_q, pc_d2_d;
    logic             one_smp_q, one_smp_d;
    logic             hist_valid_q, hist_valid_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             match;

    always_comb begin
        match        = hist_valid_q && (pc_i == pc_d2_q);
        halt_o       = en && match && (rep_cnt_q == REP_LAST);
        pc_d1_d      = pc_d1_q;
        pc_d2_d      = pc_d2_q;
        one_smp_d    = one_smp_q;
        hist_valid_d = hist_valid_q;
        rep_cnt_d    = rep_cnt_q;
        if (clr) begin
            pc_d1_d      = '0;
            pc_d2_d      = '0;
            one_smp_d    = 1'b0;
            hist_valid_d = 1'b0;
            rep_cnt_d    = '0;
        end else if (en) begin
            // pc_d2 is only meaningful after two samples, hence the one-sample flag
            pc_d1_d      = pc_i;
            pc_d2_d      = pc_d1_q;
            one_smp_d    = 1'b1;
            hist_valid_d = hist_valid_q | one_smp_q;
            rep_cnt_d    = match ? rep_cnt_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pc_d1_q      <= '0;
            pc_d2_q      <= '0;
            one_smp_q    <= 1'b0;
            hist_valid_q <= 1'b0;
            rep_cnt_q    <= '0;
        end else begin
            pc_d1_q      <= pc_d1_d;
            pc_d2_q      <= pc_d2_d;
            one_smp_q    <= one_smp_d;
            hist_valid_q <= hist_valid_d;
            rep_cnt_q    <= rep_cnt_d;
        end
    end

endmodule

// File: rtl/sopc_run_ctrl.sv
// Sequences core reset, counts RUN cycles and ends a run on PC self-loop halt or timeout.
// Latency: status outputs are decoded from the state register, one edge after the event.
// Backpressure: none; restart_i is honoured only in HALTED/TIMEOUT.
module sopc_run_ctrl
    import sopc_run_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned MAX_CYCLES   = 200,
    parameter int unsigned HALT_REPEAT  = 8,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_i,
    input  logic             restart_i,
    output logic             core_rst_o,
    output logic             running_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [31:0]      halt_pc_o
);

    localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);

    run_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [31:0]       halt_pc_q, halt_pc_d;
    logic              halt;

    sopc_run_ctrl_pc_loop_detector #(
        .HALT_REPEAT (HALT_REPEAT)
    ) u_pc_loop_detector (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == RunHold),
        .en     (state_q == RunRun),
        .pc_i   (pc_i),
        .halt_o (halt)
    );

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        halt_pc_d   = halt_pc_q;
        case (state_q)
            RunHold: begin
                cycle_cnt_d = '0;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = RunRun;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RunRun: begin
                // Halt takes priority over a coincident budget exhaustion
                if (halt) begin
                    state_d   = RunHalted;
                    halt_pc_d = pc_i;
                end else if (cycle_cnt_q == CNT_LAST) begin
                    state_d = RunTimeout;
                end else begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
            end
            RunHalted, RunTimeout: begin
                if (restart_i) begin
                    state_d     = RunHold;
                    hold_cnt_d  = '0;
                    cycle_cnt_d = '0;
                    halt_pc_d   = '0;
                end
            end
            default: state_d = RunHold;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q     <= RunHold;
            hold_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            halt_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            halt_pc_q   <= halt_pc_d;
        end
    end

    assign core_rst_o  = (state_q != RunRun);
    assign running_o   = (state_q == RunRun);
    assign done_o      = (state_q == RunHalted);
    assign timeout_o   = (state_q == RunTimeout);
    assign cycle_cnt_o = cycle_cnt_q;
    assign halt_pc_o   = halt_pc_q;

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Directed plus randomized bench for sopc_run_ctrl against a program-level halt/timeout model.
module tb_sopc_run_ctrl;

    localparam int RC = 4;
    localparam int MC = 50;
    localparam int HR = 8;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          restart_i = 1'b0;
    logic [31:0]   pc_i = '0;
    logic          core_rst_o, running_o, done_o, timeout_o;
    logic [CW-1:0] cycle_cnt_o;
    logic [31:0]   halt_pc_o;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [31:0]   prog [0:63];

    sopc_run_ctrl #(
        .RESET_CYCLES (RC),
        .MAX_CYCLES   (MC),
        .HALT_REPEAT  (HR),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_i),
        .restart_i   (restart_i),
        .core_rst_o  (core_rst_o),
        .running_o   (running_o),
        .done_o      (done_o),
        .timeout_o   (timeout_o),
        .cycle_cnt_o (cycle_cnt_o),
        .halt_pc_o   (halt_pc_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Program outcome from the rules: a match is pc[i]==pc[i-2]; HR consecutive matches halt.
    function automatic void model(output bit done, output int last, output logic [31:0] hpc);
        int rep;
        rep  = 0;
        done = 1'b0;
        last = MC - 1;
        hpc  = '0;
        for (int i = 0; i < MC; i++) begin
            if (i >= 2 && prog[i] == prog[i-2]) rep++;
            else rep = 0;
            if (rep == HR) begin
                done = 1'b1;
                last = i;
                hpc  = prog[i];
                break;
            end
        end
    endfunction

    task automatic chk_reset(input string tag);
        check({tag, " core_rst"}, 32'(core_rst_o), 32'd1);
        check({tag, " running"},  32'(running_o),  32'd0);
        check({tag, " done"},     32'(done_o),     32'd0);
        check({tag, " timeout"},  32'(timeout_o),  32'd0);
        check({tag, " cnt"},      32'(cycle_cnt_o), 32'd0);
        check({tag, " halt_pc"},  halt_pc_o,       32'd0);
    endtask

    task automatic do_restart(input string tag);
        restart_i = 1'b1;
        @(negedge clk);
        restart_i = 1'b0;
        chk_reset({tag, " restart"});
    endtask

    task automatic wait_running();
        int w;
        w = 0;
        while (!running_o && w < 20) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic run_prog(input string tag);
        bit          ed;
        int          el;
        logic [31:0] ep;
        int          i;
        model(ed, el, ep);
        wait_running();
        check({tag, " start"}, 32'(running_o), 32'd1);
        i = 0;
        while (running_o && i < 64) begin
            check({tag, " cnt"}, 32'(cycle_cnt_o), 32'(i));
            check({tag, " core_rst_run"}, 32'(core_rst_o), 32'd0);
            pc_i      = prog[i];
            restart_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            i++;
        end
        restart_i = 1'b0;
        check({tag, " run_len"},  32'(i),            32'(el + 1));
        check({tag, " done"},     32'(done_o),       32'(ed));
        check({tag, " timeout"},  32'(timeout_o),    32'(!ed));
        check({tag, " end_cnt"},  32'(cycle_cnt_o),  32'(el));
        check({tag, " halt_pc"},  halt_pc_o,         ed ? ep : 32'd0);
        check({tag, " parked"},   32'(core_rst_o),   32'd1);
        repeat (3) @(negedge clk);
        check({tag, " frozen_cnt"},  32'(cycle_cnt_o), 32'(el));
        check({tag, " frozen_done"}, 32'(done_o),      32'(ed));
    endtask

    initial begin
        int          hs;
        int          k;
        int          mode;
        logic [31:0] base;
        logic [31:0] lp;

        // reset held for 5 edges, then RESET_CYCLES further hold cycles
        repeat (5) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        hs  = 0;
        for (int w = 0; w < 20 && !running_o; w++) begin
            if (core_rst_o) hs++;
            @(negedge clk);
        end
        check("hold_cycles", 32'(hs), 32'(RC));
        check("run_rise_cycle", 32'(cyc), 32'(5 + RC));

        for (int i = 0; i < 64; i++) prog[i] = (i < 3) ? 32'(i * 4) : 32'hC;
        run_prog("const_c");

        do_restart("alt");
        base = 32'h100 + (32'($urandom_range(0, 255)) << 4);
        for (int i = 0; i < 64; i++)
            prog[i] = (i < 3) ? base + 32'(i * 4) : (((i - 3) % 2 == 0) ? 32'h20 : 32'h24);
        run_prog("alt");

        do_restart("stall");
        base = 32'h1000 + (32'($urandom_range(0, 255)) << 4);
        for (int i = 0; i < 64; i++)
            prog[i] = (i < 5) ? base : base + 32'((i - 4) * 4);
        run_prog("stall");

        do_restart("edge");
        for (int i = 0; i < 64; i++)
            prog[i] = (i < MC - 1 - (HR - 1) - 2) ? 32'h2000 + 32'(i * 4) : 32'h8000;
        run_prog("edge");

        for (int t = 0; t < 5; t++) begin
            do_restart("rand");
            k    = $urandom_range(0, 55);
            mode = $urandom_range(0, 1);
            lp   = 32'h400 + (32'($urandom_range(0, 15)) << 3);
            for (int i = 0; i < 64; i++) begin
                if (i < k) prog[i] = 32'($urandom_range(0, 3)) << 2;
                else if (mode == 0) prog[i] = lp;
                else prog[i] = ((i - k) % 2 == 0) ? lp : lp + 32'd4;
            end
            run_prog("rand");
        end

        do_restart("halt0");
        lp = 32'h3000 + (32'($urandom_range(1, 255)) << 2);
        for (int i = 0; i < 64; i++) prog[i] = lp;
        run_prog("halt0");

        // synchronous reset from HALTED clears the captured PC
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("rst_halted");

        wait_running();
        check("midrun_start", 32'(running_o), 32'd1);
        for (int i = 0; i < 6; i++) begin
            pc_i = lp;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("rst_midrun");
        for (int i = 0; i < 64; i++) prog[i] = (i < 20) ? 32'h5000 + 32'(i * 8) : lp;
        run_prog("after_rst");

        do_restart("rerun");
        run_prog("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
